// File: rtl/l2_cache_pkg.sv
// l2_cache_pkg: shared types for the L2 cache (state, line, widths).
// Geometry defaults, FSM state enum, line struct, OKAY response.
package l2_cache_pkg;

  localparam int L2_ADDR_W    = 32;
  localparam int L2_DATA_W    = 32;
  localparam int L2_NUM_LINES = 4096;

  localparam logic [1:0] AXI_OKAY = 2'b00;

  function automatic int idx_w(input int n);
    return $clog2(n);
  endfunction

  function automatic int tag_w(input int a, input int n);
    return a - 2 - $clog2(n);
  endfunction

  localparam int L2_IDX_W = idx_w(L2_NUM_LINES);
  localparam int L2_TAG_W = tag_w(L2_ADDR_W, L2_NUM_LINES);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOKUP,
    ST_EVICT,
    ST_REFILL,
    ST_RESP
  } state_t;

  // The line layout follows the package geometry above.
  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [L2_TAG_W-1:0] tag;
    logic [L2_DATA_W-1:0] data;
  } line_t;

endpackage

// File: rtl/l2_line_ram.sv
// l2_line_ram: single-port line store, synchronous read, one op per cycle.
// Ports: i_clk, i_en, i_we, i_addr, i_wline (write), o_rline (read, +1 cycle).
module l2_line_ram
  import l2_cache_pkg::*;
#(
  parameter int DEPTH = L2_NUM_LINES,
  parameter int AW    = idx_w(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_en,
  input  logic          i_we,
  input  logic [AW-1:0] i_addr,
  input  line_t         i_wline,
  output line_t         o_rline
);

  line_t r_mem [DEPTH];
  line_t r_rline;

  always_ff @(posedge i_clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_wline;
      end else begin
        r_rline <= r_mem[i_addr];
      end
    end
  end

  assign o_rline = r_rline;

endmodule

// File: rtl/l2_cache.sv
// l2_cache: direct-mapped write-back write-allocate L2, one word per line.
// Ports: AXI-lite style AW/W/B/AR/R slave from L1, simple mem_* master port.
// Optional macro L2_CACHE_STATS_EN adds stat_hits/stat_misses counters.
module l2_cache
  import l2_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = L2_ADDR_W,
  parameter int DATA_WIDTH = L2_DATA_W,
  parameter int NUM_LINES  = L2_NUM_LINES
) (
  input  logic                  s_axi_aclk,
  input  logic                  s_axi_areset,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                  s_axi_arvalid,
  output logic                  s_axi_arready,
  output logic [DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]            s_axi_rresp,
  output logic                  s_axi_rvalid,
  input  logic                  s_axi_rready,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef L2_CACHE_STATS_EN
  ,
  output logic [31:0]           stat_hits,
  output logic [31:0]           stat_misses
`endif
);

  localparam int IDX_W = idx_w(NUM_LINES);
  localparam int TAG_W = tag_w(ADDR_WIDTH, NUM_LINES);

  state_t                r_state;
  logic [IDX_W-1:0]      r_init_idx;
  logic                  r_is_wr;
  logic [TAG_W-1:0]      r_tag;
  logic [IDX_W-1:0]      r_idx;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_bvalid;
  logic                  r_rvalid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_mem_req;
  logic                  r_mem_we;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_wr_acc;
  logic                  w_rd_acc;
  logic                  w_hit;
  logic                  w_vdirty;
  logic                  w_ack;
  line_t                 w_line;
  logic                  w_ram_en;
  logic                  w_ram_we;
  logic [IDX_W-1:0]      w_ram_addr;
  line_t                 w_ram_wline;
  logic                  w_unused;

  // Byte offset within the word carries no information here.
  assign w_unused = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

  // Readies are a one-cycle pulse: IDLE always leaves on acceptance.
  assign w_wr_acc = (r_state == ST_IDLE) && !s_axi_areset
                  && s_axi_awvalid && s_axi_wvalid;
  assign w_rd_acc = (r_state == ST_IDLE) && !s_axi_areset
                  && s_axi_arvalid
                  && !(s_axi_awvalid && s_axi_wvalid);

  assign s_axi_awready = w_wr_acc;
  assign s_axi_wready  = w_wr_acc;
  assign s_axi_arready = w_rd_acc;

  assign w_hit    = w_line.valid && (w_line.tag == r_tag);
  assign w_vdirty = w_line.valid && w_line.dirty;
  // Acks outside an active request are ignored.
  assign w_ack    = r_mem_req && mem_ack;

  always_comb begin
    w_ram_en    = 1'b0;
    w_ram_we    = 1'b0;
    w_ram_addr  = r_idx;
    w_ram_wline = '0;
    if (!s_axi_areset) begin
      unique case (r_state)
        ST_INIT: begin
          w_ram_en   = 1'b1;
          w_ram_we   = 1'b1;
          w_ram_addr = r_init_idx;
        end
        ST_IDLE: begin
          if (w_wr_acc) begin
            w_ram_en   = 1'b1;
            w_ram_addr = s_axi_awaddr[2 +: IDX_W];
          end else if (w_rd_acc) begin
            w_ram_en   = 1'b1;
            w_ram_addr = s_axi_araddr[2 +: IDX_W];
          end
        end
        ST_LOOKUP: begin
          // Full-line write: no refill needed on a write miss.
          if (r_is_wr && (w_hit || !w_vdirty)) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_wline = '{valid: 1'b1, dirty: 1'b1,
                            tag: r_tag, data: r_wdata};
          end
        end
        ST_EVICT: begin
          if (r_is_wr && w_ack) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_wline = '{valid: 1'b1, dirty: 1'b1,
                            tag: r_tag, data: r_wdata};
          end
        end
        ST_REFILL: begin
          if (w_ack) begin
            w_ram_en    = 1'b1;
            w_ram_we    = 1'b1;
            w_ram_wline = '{valid: 1'b1, dirty: 1'b0,
                            tag: r_tag, data: mem_rdata};
          end
        end
        default: ;
      endcase
    end
  end

  l2_line_ram #(
    .DEPTH (NUM_LINES),
    .AW    (IDX_W)
  ) u_ram (
    .i_clk   (s_axi_aclk),
    .i_en    (w_ram_en),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wline (w_ram_wline),
    .o_rline (w_line)
  );

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_state     <= ST_INIT;
      r_init_idx  <= '0;
      r_is_wr     <= 1'b0;
      r_tag       <= '0;
      r_idx       <= '0;
      r_wdata     <= '0;
      r_bvalid    <= 1'b0;
      r_rvalid    <= 1'b0;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      unique case (r_state)
        ST_INIT: begin
          r_init_idx <= r_init_idx + 1'b1;
          if (r_init_idx == IDX_W'(NUM_LINES - 1)) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_wr_acc) begin
            r_is_wr <= 1'b1;
            r_tag   <= s_axi_awaddr[ADDR_WIDTH-1 -: TAG_W];
            r_idx   <= s_axi_awaddr[2 +: IDX_W];
            r_wdata <= s_axi_wdata;
            r_state <= ST_LOOKUP;
          end else if (w_rd_acc) begin
            r_is_wr <= 1'b0;
            r_tag   <= s_axi_araddr[ADDR_WIDTH-1 -: TAG_W];
            r_idx   <= s_axi_araddr[2 +: IDX_W];
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            if (r_is_wr) begin
              r_bvalid <= 1'b1;
            end else begin
              r_rdata  <= w_line.data;
              r_rvalid <= 1'b1;
            end
            r_state <= ST_RESP;
          end else if (w_vdirty) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= 1'b1;
            r_mem_addr  <= {w_line.tag, r_idx, 2'b00};
            r_mem_wdata <= w_line.data;
            r_state     <= ST_EVICT;
          end else if (r_is_wr) begin
            r_bvalid <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_state <= ST_REFILL;
          end
        end
        ST_EVICT: begin
          if (w_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (r_is_wr) begin
              r_bvalid <= 1'b1;
              r_state  <= ST_RESP;
            end else begin
              r_state <= ST_REFILL;
            end
          end
        end
        ST_REFILL: begin
          // Request is raised on entry, so it always drops for
          // a cycle between an eviction and its refill.
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= {r_tag, r_idx, 2'b00};
          end else if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_rdata   <= mem_rdata;
            r_rvalid  <= 1'b1;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (r_is_wr && s_axi_bready) begin
            r_bvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end else if (!r_is_wr && s_axi_rready) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_INIT;
      endcase
    end
  end

  assign s_axi_bresp  = AXI_OKAY;
  assign s_axi_rresp  = AXI_OKAY;
  assign s_axi_bvalid = r_bvalid;
  assign s_axi_rvalid = r_rvalid;
  assign s_axi_rdata  = r_rdata;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

`ifdef L2_CACHE_STATS_EN
  logic [31:0] r_hits;
  logic [31:0] r_misses;

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      r_hits   <= '0;
      r_misses <= '0;
    end else if (r_state == ST_LOOKUP) begin
      if (w_hit && (r_hits != '1)) begin
        r_hits <= r_hits + 1'b1;
      end
      if (!w_hit && (r_misses != '1)) begin
        r_misses <= r_misses + 1'b1;
      end
    end
  end

  assign stat_hits   = r_hits;
  assign stat_misses = r_misses;
`endif

endmodule

// File: doc/l2_cache.md
L2_CACHE -- requirements
Module: l2_cache

Interface
REQ-001 The block SHALL have exactly one clock, s_axi_aclk, and one reset, s_axi_areset, which is synchronous and active-high.
REQ-002 Parameters: ADDR_WIDTH, 32, byte address width; DATA_WIDTH, 32, word and line width; NUM_LINES, 4096, direct-mapped line count (power of two).
REQ-003 Ports: s_axi_aclk  in  1  clock; s_axi_areset  in  1  synchronous active-high reset.
REQ-004 s_axi_awaddr  in  32  L1 write address; s_axi_awvalid  in  1; s_axi_awready  out  1.
REQ-005 s_axi_wdata  in  32  L1 write data; s_axi_wvalid  in  1; s_axi_wready  out  1.
REQ-006 s_axi_bresp  out  2  always OKAY (00); s_axi_bvalid  out  1; s_axi_bready  in  1.
REQ-007 s_axi_araddr  in  32  L1 read address; s_axi_arvalid  in  1; s_axi_arready  out  1.
REQ-008 s_axi_rdata  out  32; s_axi_rresp  out  2  always OKAY; s_axi_rvalid  out  1; s_axi_rready  in  1.
REQ-009 mem_req  out  1; mem_we  out  1; mem_addr  out  32  word-aligned; mem_wdata  out  32; mem_ack  in  1  single-cycle completion pulse; mem_rdata  in  32  valid with mem_ack.

Function
REQ-010 Organisation SHALL be direct-mapped, write-back, write-allocate; one 32-bit word per line; index = addr[2 +: log2(NUM_LINES)], tag = remaining upper bits; addr[1:0] ignored.
REQ-011 States SHALL be INIT, IDLE, LOOKUP, EVICT, REFILL, RESP.
REQ-012 INIT: clear valid and dirty of one line per cycle, index 0..NUM_LINES-1, then IDLE; all ready outputs low throughout.
REQ-013 IDLE: a write is accepted only when awvalid and wvalid are both high, with awready and wready pulsed together for one cycle; a read is accepted on arvalid via a one-cycle arready pulse.
REQ-014 Simultaneous write and read requests in IDLE SHALL accept the write; the read remains pending.
REQ-015 LOOKUP (one cycle after acceptance): hit = valid and tag match. On hit, go to RESP. On miss with the victim dirty, go to EVICT; on miss with the victim clean, write misses go to RESP and read misses go to REFILL.
REQ-016 Write hit, and write miss after any eviction, SHALL store wdata, set valid=1, dirty=1, tag=new, with no refill (full-line write).
REQ-017 EVICT: mem_req=1, mem_we=1, mem_addr={victim tag, index, 2'b00}, mem_wdata=victim data, held stable until mem_ack; then REFILL for reads and RESP for writes.
REQ-018 REFILL: mem_req=1, mem_we=0, mem_addr={tag, index, 2'b00} held until mem_ack; mem_rdata installed with valid=1, dirty=0; then RESP.
REQ-019 RESP: bvalid (write) or rvalid (read) asserted and held with stable rdata until the matching ready is high; then IDLE. Hit latency SHALL be accept+2 cycles to valid.
REQ-020 Only one transaction SHALL be outstanding; no new request is accepted outside IDLE.
REQ-021 mem_req SHALL deassert the cycle after mem_ack; a mem_ack received while mem_req is low SHALL be ignored.

Reset
REQ-022 On s_axi_areset, state becomes INIT, and all valid, ready, mem_req, mem_we, resp and data outputs become 0; the statistics counters also clear.
REQ-023 Reset mid-transaction SHALL abandon it with no write-back, with mem_req low the following cycle.

Configuration
REQ-024 With L2_CACHE_STATS_EN defined, the block SHALL add outputs stat_hits and stat_misses (32 bits each), each incrementing once per LOOKUP and saturating at all-ones. Without the macro, these ports and their logic SHALL be absent and behaviour is otherwise identical.

Structure
REQ-025 Package l2_cache_pkg SHALL hold the state enum, the line struct (valid, dirty, tag, data), the OKAY constant, and the index/tag width functions.
REQ-026 The line array SHALL be a single sub-module, l2_line_ram (single-port, synchronous read, one read or write per cycle).

Verification
REQ-027 After reset, with 4096 INIT cycles complete: read 0x0000_1000 -> REFILL mem_addr 0x0000_1000; mem_rdata 0xCAFE_0001 returned as rdata with rresp 00.
REQ-028 Repeat read 0x0000_1000 -> no mem_req; rvalid 2 cycles after arready.
REQ-029 Write 0x0000_1000 = 0x1234_5678, then read 0x0001_1000 (same index) -> EVICT mem_we=1, addr 0x0000_1000, data 0x1234_5678, then REFILL 0x0001_1000.
REQ-030 awvalid+wvalid+arvalid in the same cycle -> write accepted first; the read is accepted only after bvalid/bready.
REQ-031 rready held low for 5 cycles -> rvalid and rdata held stable; assert reset during REFILL -> mem_req low the next cycle, INIT restarts.
